branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch/jump resolver.
- Adds a direct-mapped branch target buffer (BTB) with saturating-counter direction prediction, looked up from the IF-stage PC.
- Resolves conditional branches, JAL and JALR in EX and compares the result against the prediction carried down the pipe.
- Raises a one-cycle redirect/flush on mispredict and trains the tables on the next clock edge.

Parameters:
- XLEN, 32, datapath and PC width.
- BTB_ENTRIES, 64, table depth; power of two, at least 2; IDX = log2(BTB_ENTRIES).
- CTR_BITS, 2, saturating-counter width (1 to 4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- if_pc  in  XLEN  fetch PC for lookup.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  XLEN  predicted target; equals if_pc+4 when pred_taken=0.
- ex_valid  in  1  EX holds a valid, non-stalled instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_rs1  in  XLEN  rs1 operand (forwarded).
- ex_is_branch  in  1  conditional branch.
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_funct3  in  3  branch condition.
- ex_zero  in  1  ALU compare: equal.
- ex_less  in  1  ALU compare: signed less-than.
- ex_less_u  in  1  ALU compare: unsigned less-than.
- ex_pred_taken  in  1  prediction made at fetch for this instruction.
- ex_pred_target  in  XLEN  target predicted at fetch.
- redirect_valid  out  1  mispredict; fetch must load redirect_pc.
- redirect_pc  out  XLEN  correct next PC.
- flush_pipe  out  1  kill IF/ID; equals redirect_valid.

Behaviour:
- Indexing: idx = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]. Each entry holds valid, tag, target[XLEN-1:0] and ctr[CTR_BITS-1:0].
- Lookup is combinational from if_pc. It hits when valid and tags match. pred_taken = hit & ctr MSB. pred_target = pred_taken ? entry target : if_pc+4.
- Resolution is combinational in EX and is only meaningful when ex_valid=1.
- Conditions by ex_funct3:
  - 000 BEQ: zero
  - 001 BNE: !zero
  - 100 BLT: less
  - 101 BGE: !less
  - 110 BLTU: less_u
  - 111 BGEU: !less_u
  - 010 and 011: never taken
- JAL and JALR are always taken. JAL and branch target = ex_pc+ex_imm. JALR target = (ex_rs1+ex_imm) & ~1. All sums wrap modulo 2^XLEN.
- Mispredict = ex_valid & (actual_taken != ex_pred_taken | (actual_taken & target != ex_pred_target)).
- Non-control instructions are treated as actual not-taken, so a false BTB hit on them is a mispredict.
- redirect_pc = actual_taken ? target : ex_pc+4. redirect_valid and flush_pipe equal the mispredict signal, same cycle, with no register.
- Update on the clock edge when ex_valid and the instruction is branch, JAL or JALR:
  - Entry at idx(ex_pc) gets valid=1, tag=tag(ex_pc) and target=resolved target (written only if taken).
  - On a tag miss the entry is allocated with ctr = taken ? 10..0 (weak taken) : 01..1 (weak not-taken). A not-taken branch on a miss does not allocate.
  - On a hit, ctr increments on taken and decrements on not-taken, saturating at all-ones and zero.
  - JAL/JALR set ctr to all-ones.
- False hit on a non-control instruction (ex_valid, not branch/jump, tag hit): the entry's valid bit is cleared.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents (no bypass).
- More than one of ex_is_branch/ex_is_jal/ex_is_jalr set: priority jalr > jal > branch.
- Reset: all valid bits=0, all ctr=01..1 (1 for CTR_BITS=1). Combinational outputs follow their inputs. With every entry invalid, pred_taken=0 and pred_target=if_pc+4.
- rst asserted mid-operation: the table is cleared on that edge and no update from the same cycle is retained.

Optional Feature:
- Macro BPU_STATS_EN. When defined, adds two outputs:
  - stat_ctrl  out  32: count of resolved control instructions.
  - stat_mispred  out  32: count of mispredicts.
- Both increment on the clock edge when their condition holds, wrap at 2^32 and clear to 0 on rst.
- When not defined, these ports and their registers do not exist.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104. Resolve BEQ at 0x100, imm=0x40, zero=1, pred_taken=0 -> redirect_valid=1, redirect_pc=0x140. Next cycle, lookup 0x100 -> pred_taken=1, pred_target=0x140.
- Counter saturation: same BEQ resolved taken 4 times, then not-taken once -> still predicts taken. A second not-taken -> predicts not-taken (CTR_BITS=2).
- JALR with rs1=0x2001, imm=0x10 -> redirect_pc=0x2010 (bit0 cleared). Entry ctr becomes 11.
- Aliasing: PCs 0x100 and 0x100+4*BTB_ENTRIES map to the same index -> second PC replaces the entry. Lookup of the first PC then misses.
- Correct prediction: pred_taken=1, pred_target=0x140, actual target 0x140 -> redirect_valid=0. A wrong ex_pred_target of 0x144 -> redirect_valid=1, redirect_pc=0x140.
- BPU_STATS_EN: 10 resolutions with 3 mispredicts -> stat_ctrl=10, stat_mispred=3. After rst -> both read 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// ============================================================================
// Module   : branch_predict_unit
// Summary  : Direct-mapped BTB with saturating-counter direction prediction,
//            EX-stage branch/JAL/JALR resolution and mispredict redirect.
//            Optional macro BPU_STATS_EN adds resolution/mispredict counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int CTR_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_zero,
    input  logic            ex_less,
    input  logic            ex_less_u,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_pipe
`ifdef BPU_STATS_EN
    ,output logic [31:0]    stat_ctrl
    ,output logic [31:0]    stat_mispred
`endif
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_RST = (CTR_BITS == 1) ? CTR_MAX : CTR_WT - CTR_BITS'(1);
    localparam logic [XLEN-1:0]     PC_STEP = XLEN'(4);

    logic                valid_q  [BTB_ENTRIES];
    logic [TAGW-1:0]     tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];

    logic [IDX-1:0]  if_idx;
    logic [TAGW-1:0] if_tag;
    logic            if_hit;

    assign if_idx = if_pc[IDX+1:2];
    assign if_tag = if_pc[XLEN-1:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign pred_taken  = if_hit && ctr_q[if_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;

    logic [IDX-1:0]      ex_idx;
    logic [TAGW-1:0]     ex_tag;
    logic                ex_hit;
    logic [CTR_BITS-1:0] ex_ctr;
    logic                is_jump;
    logic                is_ctrl;
    logic                br_cond;
    logic                actual_taken;
    logic [XLEN-1:0]     act_target;
    logic                mispredict;

    assign ex_idx  = ex_pc[IDX+1:2];
    assign ex_tag  = ex_pc[XLEN-1:IDX+2];
    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ex_ctr  = ctr_q[ex_idx];
    assign is_jump = ex_is_jal || ex_is_jalr;
    assign is_ctrl = is_jump || ex_is_branch;

    always_comb begin
        br_cond = 1'b0;
        case (ex_funct3)
            3'b000:  br_cond = ex_zero;
            3'b001:  br_cond = !ex_zero;
            3'b100:  br_cond = ex_less;
            3'b101:  br_cond = !ex_less;
            3'b110:  br_cond = ex_less_u;
            3'b111:  br_cond = !ex_less_u;
            default: br_cond = 1'b0;
        endcase
    end

    // Priority jalr > jal > branch; non-control instructions resolve not-taken.
    always_comb begin
        actual_taken = 1'b0;
        act_target   = ex_pc + ex_imm;
        if (ex_is_jalr) begin
            actual_taken = 1'b1;
            act_target   = (ex_rs1 + ex_imm) & ~XLEN'(1);
        end else if (ex_is_jal) begin
            actual_taken = 1'b1;
        end else if (ex_is_branch) begin
            actual_taken = br_cond;
        end
    end

    assign mispredict = ex_valid &&
                        ((actual_taken != ex_pred_taken) ||
                         (actual_taken && (act_target != ex_pred_target)));

    assign redirect_valid = mispredict;
    assign flush_pipe     = mispredict;
    assign redirect_pc    = actual_taken ? act_target : ex_pc + PC_STEP;

    logic                wr_en;
    logic                wr_tgt_en;
    logic                inv_en;
    logic [CTR_BITS-1:0] ctr_d;

    always_comb begin
        wr_en     = 1'b0;
        wr_tgt_en = 1'b0;
        inv_en    = 1'b0;
        ctr_d     = ex_ctr;
        if (ex_valid) begin
            if (is_ctrl) begin
                if (is_jump) begin
                    wr_en     = 1'b1;
                    wr_tgt_en = 1'b1;
                    ctr_d     = CTR_MAX;
                end else if (ex_hit) begin
                    wr_en     = 1'b1;
                    wr_tgt_en = actual_taken;
                    if (actual_taken) begin
                        ctr_d = (ex_ctr == CTR_MAX) ? ex_ctr : ex_ctr + CTR_BITS'(1);
                    end else begin
                        ctr_d = (ex_ctr == '0) ? ex_ctr : ex_ctr - CTR_BITS'(1);
                    end
                end else if (actual_taken) begin
                    wr_en     = 1'b1;
                    wr_tgt_en = 1'b1;
                    ctr_d     = CTR_WT;
                end
            end else if (ex_hit) begin
                // A BTB hit on a non-control instruction is stale; drop it.
                inv_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RST;
            end
        end else if (wr_en) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            ctr_q[ex_idx]   <= ctr_d;
            if (wr_tgt_en) begin
                target_q[ex_idx] <= act_target;
            end
        end else if (inv_en) begin
            valid_q[ex_idx] <= 1'b0;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] stat_ctrl_q;
    logic [31:0] stat_mispred_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ctrl_q    <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (ex_valid && is_ctrl) begin
                stat_ctrl_q <= stat_ctrl_q + 32'd1;
            end
            if (mispredict) begin
                stat_mispred_q <= stat_mispred_q + 32'd1;
            end
        end
    end

    assign stat_ctrl    = stat_ctrl_q;
    assign stat_mispred = stat_mispred_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// ============================================================================
// Module   : tb_branch_predict_unit
// Summary  : Scoreboard bench for branch_predict_unit with directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs1;
    logic        ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic        ex_zero, ex_less, ex_less_u;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_pipe;
`ifdef BPU_STATS_EN
    logic [31:0] stat_ctrl, stat_mispred;
`endif

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_less(ex_less), .ex_less_u(ex_less_u),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush_pipe(flush_pipe)
`ifdef BPU_STATS_EN
        , .stat_ctrl(stat_ctrl), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          cp;
        logic        pt;
        logic [31:0] ptgt;
        bit          cr;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] sc;
        logic [31:0] sm;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] e_ctrl = 0;
    logic [31:0] e_mis  = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cp) begin
                cmp(e.name, "pred_taken", {31'd0, pred_taken}, {31'd0, e.pt});
                cmp(e.name, "pred_target", pred_target, e.ptgt);
            end
            if (e.cr) begin
                cmp(e.name, "redirect_valid", {31'd0, redirect_valid}, {31'd0, e.rv});
                cmp(e.name, "flush_pipe", {31'd0, flush_pipe}, {31'd0, e.rv});
                cmp(e.name, "redirect_pc", redirect_pc, e.rpc);
            end
`ifdef BPU_STATS_EN
            cmp(e.name, "stat_ctrl", stat_ctrl, e.sc);
            cmp(e.name, "stat_mispred", stat_mispred, e.sm);
`endif
        end
    end

    task automatic vec(input string nm, input logic [31:0] ipc, input logic v,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic z, input logic l, input logic lu,
                       input logic ptk, input logic [31:0] ptg,
                       input bit cp, input logic ept, input logic [31:0] eptg,
                       input bit cr, input logic erv, input logic [31:0] erpc);
        exp_t e;
        if_pc = ipc; ex_valid = v; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1;
        ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr; ex_funct3 = f3;
        ex_zero = z; ex_less = l; ex_less_u = lu;
        ex_pred_taken = ptk; ex_pred_target = ptg;
        e.name = nm; e.cp = cp; e.pt = ept; e.ptgt = eptg;
        e.cr = cr; e.rv = erv; e.rpc = erpc; e.sc = e_ctrl; e.sm = e_mis;
        if (cp || cr) sb.push_back(e);
        if (v && (br || jal || jalr)) e_ctrl++;
        if (v && erv) e_mis++;
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string nm, input logic [31:0] ipc, input logic ept, input logic [31:0] eptg);
        vec(nm, ipc, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 32'h0,
            1, ept, eptg, 1, 0, 32'h4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        if_pc = 0; ex_valid = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
        ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_funct3 = 0;
        ex_zero = 0; ex_less = 0; ex_less_u = 0; ex_pred_taken = 0; ex_pred_target = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        look("reset_lookup", 32'h100, 0, 32'h104);
        // First BEQ taken: miss, allocate weak-taken; lookup same cycle sees old state
        vec("beq_first", 32'h100, 1, 32'h100, 32'h40, 0, 1, 0, 0, 3'b000, 1, 0, 0, 0, 32'h104,
            1, 0, 32'h104, 1, 1, 32'h140);
        look("after_alloc", 32'h100, 1, 32'h140);
        for (int i = 0; i < 4; i++)
            vec("beq_correct", 32'h100, 1, 32'h100, 32'h40, 0, 1, 0, 0, 3'b000, 1, 0, 0, 1, 32'h140,
                1, 1, 32'h140, 1, 0, 32'h140);
        vec("beq_nt1", 32'h100, 1, 32'h100, 32'h40, 0, 1, 0, 0, 3'b000, 0, 0, 0, 1, 32'h140,
            1, 1, 32'h140, 1, 1, 32'h104);
        look("sat_still_taken", 32'h100, 1, 32'h140);
        vec("beq_nt2", 32'h100, 1, 32'h100, 32'h40, 0, 1, 0, 0, 3'b000, 0, 0, 0, 1, 32'h140,
            1, 1, 32'h140, 1, 1, 32'h104);
        look("now_not_taken", 32'h100, 0, 32'h104);
        vec("wrong_target", 32'h100, 1, 32'h100, 32'h40, 0, 1, 0, 0, 3'b000, 1, 0, 0, 1, 32'h144,
            1, 0, 32'h104, 1, 1, 32'h140);
        look("retrained", 32'h100, 1, 32'h140);

        vec("jalr", 32'h208, 1, 32'h208, 32'h10, 32'h2001, 0, 0, 1, 3'b000, 0, 0, 0, 0, 32'h20C,
            1, 0, 32'h20C, 1, 1, 32'h2010);
        look("jalr_lookup", 32'h208, 1, 32'h2010);
        vec("bne_nt_at_jalr", 32'h208, 1, 32'h208, 32'h10, 0, 1, 0, 0, 3'b001, 1, 0, 0, 1, 32'h2010,
            1, 1, 32'h2010, 1, 1, 32'h20C);
        look("ctr_was_max", 32'h208, 1, 32'h2010);

        vec("alias_jal", 32'h100, 1, 32'h200, 32'h20, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h204,
            1, 1, 32'h140, 1, 1, 32'h220);
        look("alias_old_miss", 32'h100, 0, 32'h104);
        look("alias_new_hit", 32'h200, 1, 32'h220);
        vec("false_hit", 32'h200, 1, 32'h200, 32'h0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 32'h220,
            1, 1, 32'h220, 1, 1, 32'h204);
        look("false_hit_cleared", 32'h200, 0, 32'h204);

        vec("bne_t",  32'h500, 1, 32'h40C, 32'h8, 0, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h410, 1, 0, 32'h504, 1, 1, 32'h414);
        vec("beq_nt", 32'h500, 1, 32'h40C, 32'h8, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0, 32'h410, 1, 0, 32'h504, 1, 0, 32'h410);
        vec("blt_t",  32'h500, 1, 32'h40C, 32'h8, 0, 1, 0, 0, 3'b100, 0, 1, 0, 0, 32'h410, 1, 0, 32'h504, 1, 1, 32'h414);
        vec("bge_nt", 32'h500, 1, 32'h40C, 32'h8, 0, 1, 0, 0, 3'b101, 0, 1, 0, 0, 32'h410, 1, 0, 32'h504, 1, 0, 32'h410);
        vec("bltu_t", 32'h500, 1, 32'h40C, 32'h8, 0, 1, 0, 0, 3'b110, 0, 0, 1, 0, 32'h410, 1, 0, 32'h504, 1, 1, 32'h414);
        vec("bgeu_t", 32'h500, 1, 32'h40C, 32'h8, 0, 1, 0, 0, 3'b111, 0, 0, 0, 0, 32'h410, 1, 0, 32'h504, 1, 1, 32'h414);
        vec("f3_010", 32'h500, 1, 32'h40C, 32'h8, 0, 1, 0, 0, 3'b010, 1, 1, 1, 0, 32'h410, 1, 0, 32'h504, 1, 0, 32'h410);

        vec("prio_jalr", 32'h500, 1, 32'h600, 32'h5, 32'h1000, 1, 1, 1, 3'b000, 1, 0, 0, 0, 32'h604,
            1, 0, 32'h504, 1, 1, 32'h1004);
        vec("wrap_jal", 32'hFFFFFFFC, 1, 32'hFFFFFFF0, 32'h20, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'hFFFFFFF4,
            1, 0, 32'h0, 1, 1, 32'h10);
        look("wrap_hit", 32'hFFFFFFF0, 1, 32'h10);

        rst = 1'b1;
        vec("mid_reset", 32'h700, 1, 32'h700, 32'h4, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 32'h704,
            0, 0, 32'h0, 0, 0, 32'h0);
        e_ctrl = 0;
        e_mis  = 0;
        rst = 1'b0;
        look("post_rst_600", 32'h600, 0, 32'h604);
        look("post_rst_700", 32'h700, 0, 32'h704);
        look("post_rst_wrap", 32'hFFFFFFF0, 0, 32'hFFFFFFF4);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
